axi_sram_slave: RTL and testbench



---
 rtl/axi_sram_slave_if.sv | 62 ++++++
 rtl/axi_sram_slave.sv | 205 ++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: AXI4 bus from the core's 64-bit master port.
// Holds the AW/W/B/AR/R channels. The master modport is the core side.
// The slave modport is the SRAM bridge side.
interface axi_sram_slave_if #(
   parameter int ID_WIDTH = 4
) ();
   logic [ID_WIDTH-1:0] awid;
   logic [31:0]         awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [63:0]         wdata;
   logic [7:0]          wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [ID_WIDTH-1:0] bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ID_WIDTH-1:0] arid;
   logic [31:0]         araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid;
   logic                arready;
   logic [ID_WIDTH-1:0] rid;
   logic [63:0]         rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave serving bursts from a single-port sync SRAM.
// It makes one SRAM access per beat, at one beat per clock in each direction.
// Ports: clock, reset (sync, active-high), SAXI (slave modport),
//   sram_en/sram_we/sram_addr/sram_wdata out, sram_rdata in.
// Build option AXI_SRAM_WRAP_BURST_EN enables WRAP bursts of 2/4/8/16 beats.
// Without it, every WRAP burst is answered as an SLVERR burst.
module axi_sram_slave #(
   parameter int ADDR_WIDTH = 16,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   axi_sram_slave_if.slave       SAXI,
   output logic                  sram_en,
   output logic [7:0]            sram_we,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [63:0]           sram_wdata,
   input  logic [63:0]           sram_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, WRESP} state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   state_t              r_state;
   state_t              w_next;
   logic                r_prio;
   logic [ID_WIDTH-1:0] r_id;
   logic [31:0]         r_addr;
   logic [2:0]          r_size;
   logic [1:0]          r_burst;
   logic [8:0]          r_beats;
   logic                r_err;
   logic                r_rvalid;
   logic                r_rlast;
   logic [1:0]          r_rresp;
`ifdef AXI_SRAM_WRAP_BURST_EN
   logic [7:0]          r_len;
`endif

   logic                w_sel_rd;
   logic                w_sel_wr;
   logic                w_ar_hs;
   logic                w_aw_hs;
   logic [ID_WIDTH-1:0] w_a_id;
   logic [31:0]         w_a_addr;
   logic [7:0]          w_a_len;
   logic [2:0]          w_a_size;
   logic [1:0]          w_a_burst;
   logic                w_a_err;
   logic [31:0]         w_incr;
   logic [31:0]         w_next_addr;
   logic                w_issue;
   logic                w_wbeat;
   logic                w_unused;

   // wlast carries no information here: the beat count ends the burst.
   assign w_unused = SAXI.wlast;

   // r_prio low means read wins a simultaneous request.
   assign w_sel_rd = SAXI.arvalid & (~SAXI.awvalid | ~r_prio);
   assign w_sel_wr = SAXI.awvalid & ~w_sel_rd;
   assign w_ar_hs  = (r_state == IDLE) & ~reset & w_sel_rd;
   assign w_aw_hs  = (r_state == IDLE) & ~reset & w_sel_wr;

   assign w_a_id    = w_sel_rd ? SAXI.arid    : SAXI.awid;
   assign w_a_addr  = w_sel_rd ? SAXI.araddr  : SAXI.awaddr;
   assign w_a_len   = w_sel_rd ? SAXI.arlen   : SAXI.awlen;
   assign w_a_size  = w_sel_rd ? SAXI.arsize  : SAXI.awsize;
   assign w_a_burst = w_sel_rd ? SAXI.arburst : SAXI.awburst;

   always_comb begin
`ifdef AXI_SRAM_WRAP_BURST_EN
      w_a_err = (w_a_burst == 2'b11) |
                ((w_a_burst == 2'b10) &
                 ~((w_a_len == 8'd1) | (w_a_len == 8'd3) |
                   (w_a_len == 8'd7) | (w_a_len == 8'd15)));
`else
      w_a_err = w_a_burst[1];
`endif
   end

   // Address math runs on the full 32 bits; the SRAM sees a truncated slice.
   assign w_incr = r_addr + (32'd1 << r_size);

`ifdef AXI_SRAM_WRAP_BURST_EN
   logic [31:0] w_wmask;
   assign w_wmask = (({24'd0, r_len} + 32'd1) << r_size) - 32'd1;
`endif

   always_comb begin
      w_next_addr = r_addr;
      case (r_burst)
         2'b01: w_next_addr = w_incr;
`ifdef AXI_SRAM_WRAP_BURST_EN
         2'b10: w_next_addr = (r_addr & ~w_wmask) | (w_incr & w_wmask);
`endif
         default: w_next_addr = r_addr;
      endcase
   end

   // A read beat is fetched whenever the output slot is free or draining.
   assign w_issue = (r_state == RD) & (r_beats != 9'd0) &
                    (~r_rvalid | SAXI.rready);
   assign w_wbeat = (r_state == WR) & SAXI.wvalid;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      SAXI.arready = 1'b0;
      SAXI.awready = 1'b0;
      SAXI.wready  = 1'b0;
      SAXI.bvalid  = 1'b0;
      sram_en      = 1'b0;
      sram_we      = 8'h00;
      unique case (r_state)
         IDLE: begin
            SAXI.arready = w_ar_hs;
            SAXI.awready = w_aw_hs;
            if (w_ar_hs)      w_next = RD;
            else if (w_aw_hs) w_next = WR;
         end
         RD: begin
            sram_en = w_issue & ~r_err & ~reset;
            if (r_rvalid & SAXI.rready & r_rlast) w_next = IDLE;
         end
         WR: begin
            SAXI.wready = ~reset;
            if (SAXI.wvalid) begin
               sram_en = ~r_err & ~reset;
               sram_we = (~r_err & ~reset) ? SAXI.wstrb : 8'h00;
               if (r_beats == 9'd1) w_next = WRESP;
            end
         end
         WRESP: begin
            SAXI.bvalid = ~reset;
            if (SAXI.bready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_prio   <= 1'b0;
         r_id     <= '0;
         r_addr   <= 32'd0;
         r_size   <= 3'd0;
         r_burst  <= 2'd0;
         r_beats  <= 9'd0;
         r_err    <= 1'b0;
         r_rvalid <= 1'b0;
         r_rlast  <= 1'b0;
         r_rresp  <= OKAY;
`ifdef AXI_SRAM_WRAP_BURST_EN
         r_len    <= 8'd0;
`endif
      end else begin
         if (w_ar_hs | w_aw_hs) begin
            r_prio  <= ~r_prio;
            r_id    <= w_a_id;
            r_addr  <= w_a_addr;
            r_size  <= w_a_size;
            r_burst <= w_a_burst;
            r_beats <= {1'b0, w_a_len} + 9'd1;
            r_err   <= w_a_err;
`ifdef AXI_SRAM_WRAP_BURST_EN
            r_len   <= w_a_len;
`endif
         end
         if (w_issue) begin
            r_beats  <= r_beats - 9'd1;
            r_addr   <= w_next_addr;
            r_rvalid <= 1'b1;
            r_rlast  <= (r_beats == 9'd1);
            r_rresp  <= r_err ? SLVERR : OKAY;
         end else if (r_rvalid & SAXI.rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
         if (w_wbeat) begin
            r_beats <= r_beats - 9'd1;
            r_addr  <= w_next_addr;
         end
      end
   end

   assign sram_addr  = r_addr[ADDR_WIDTH+2:3];
   assign sram_wdata = SAXI.wdata;

   assign SAXI.rvalid = r_rvalid;
   assign SAXI.rlast  = r_rlast;
   assign SAXI.rresp  = r_rresp;
   assign SAXI.rid    = r_id;
   // Error bursts never read the SRAM, so their beats carry zero.
   assign SAXI.rdata  = r_err ? 64'd0 : sram_rdata;
   assign SAXI.bid    = r_id;
   assign SAXI.bresp  = r_err ? SLVERR : OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave.
// A reference memory plus expected-beat queues are compared against the DUT every cycle.
module tb_axi_sram_slave;
   localparam int AW = 16;
   localparam int IW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   axi_sram_slave_if #(.ID_WIDTH(IW)) bus ();

   logic          sram_en;
   logic [7:0]    sram_we;
   logic [AW-1:0] sram_addr;
   logic [63:0]   sram_wdata;
   logic [63:0]   sram_rdata = 64'd0;

   axi_sram_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
      .clock      (clock),
      .reset      (reset),
      .SAXI       (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   function automatic logic [63:0] init_val(int a);
      logic [15:0] w;
      w = a[15:0];
      return {16'hC0DE, w, 16'hBEEF, w};
   endfunction

   // SRAM device attached to the DUT
   logic [63:0] mem [int];
   function automatic logic [63:0] mem_rd(int a);
      return mem.exists(a) ? mem[a] : init_val(a);
   endfunction
   always @(posedge clock) begin
      logic [63:0] t;
      int a;
      if (sram_en) begin
         a = int'(sram_addr);
         if (sram_we == 8'h00) sram_rdata <= mem_rd(a);
         else begin
            t = mem_rd(a);
            for (int b = 0; b < 8; b++)
               if (sram_we[b]) t[b*8 +: 8] = sram_wdata[b*8 +: 8];
            mem[a] = t;
         end
      end
   end

   // Reference model
   logic [63:0] ref_mem [int];
   function automatic logic [63:0] ref_rd(int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
   endfunction
   function automatic int word_of(logic [31:0] a);
      return int'((a >> 3) & ((32'd1 << AW) - 32'd1));
   endfunction
   function automatic bit is_err(logic [1:0] burst, logic [7:0] len);
`ifdef AXI_SRAM_WRAP_BURST_EN
      return (burst == 2'b11) ||
             (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
`else
      return burst >= 2'b10;
`endif
   endfunction
   function automatic logic [31:0] next_a(logic [31:0] a, logic [7:0] len,
                                          logic [2:0] size, logic [1:0] burst);
      logic [31:0] step, ws;
      step = 32'd1 << size;
      ws = (32'(len) + 32'd1) << size;
      if (burst == 2'b01) return a + step;
      if (burst == 2'b10) return (a & ~(ws - 1)) | ((a + step) & (ws - 1));
      return a;
   endfunction

   typedef struct packed {
      logic [IW-1:0] id;
      logic [63:0]   data;
      logic [1:0]    resp;
      logic          last;
   } rbeat_t;
   typedef struct packed {
      logic [IW-1:0] id;
      logic [1:0]    resp;
   } bresp_t;
   rbeat_t rq[$];
   bresp_t bq[$];

   int n_pass = 0;
   int n_tot  = 0;
   int cyc    = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic tmo(string nm);
      n_tot++;
      $display("FAIL %s: timeout at cycle %0d", nm, cyc);
   endtask

   // Monitor state
   logic [63:0] rd_log[$];
   logic [AW-1:0] addr_log[$];
   int hs_log[$];
   int n_rhs = 0, n_en = 0, first_rv = -1, first_bv = -1;
   logic [1:0] last_rresp = 2'd0, last_bresp = 2'd0;
   logic [IW-1:0] last_bid = '0;
   bit prev_stall = 0;
   logic [63:0] prev_data = 64'd0;
   logic prev_last = 1'b0;

   // Compare process
   always @(negedge clock) begin
      rbeat_t e;
      bresp_t eb;
      if (reset) prev_stall = 0;
      else begin
         if (prev_stall) begin
            chk("r_hold_valid", bus.rvalid, 1);
            chk("r_hold_data", bus.rdata, prev_data);
            chk("r_hold_last", bus.rlast, prev_last);
         end
         if (bus.rvalid && first_rv < 0) first_rv = cyc;
         if (bus.bvalid && first_bv < 0) first_bv = cyc;
         if (bus.rvalid && bus.rready) begin
            n_rhs++;
            hs_log.push_back(cyc);
            rd_log.push_back(bus.rdata);
            last_rresp = bus.rresp;
            if (rq.size() == 0) tmo("r_unexpected_beat");
            else begin
               e = rq.pop_front();
               chk("r_data", bus.rdata, e.data);
               chk("r_resp", bus.rresp, e.resp);
               chk("r_last", bus.rlast, e.last);
               chk("r_id", bus.rid, e.id);
            end
         end
         if (bus.bvalid && bus.bready) begin
            last_bresp = bus.bresp;
            last_bid = bus.bid;
            if (bq.size() == 0) tmo("b_unexpected");
            else begin
               eb = bq.pop_front();
               chk("b_id", bus.bid, eb.id);
               chk("b_resp", bus.bresp, eb.resp);
            end
         end
         if (sram_en) begin
            n_en++;
            addr_log.push_back(sram_addr);
         end
         prev_stall = bus.rvalid && !bus.rready;
         prev_data = bus.rdata;
         prev_last = bus.rlast;
      end
   end

   // Stimulus helpers
   logic [63:0] wdat [0:7];
   logic [7:0]  wstb [0:7];
   int ar_cyc = 0, aw_cyc = 0, wf_cyc = 0, wl_cyc = 0;
   logic [IW-1:0] m_wid;
   logic [31:0] m_waddr;
   logic [7:0] m_wlen;
   logic [2:0] m_wsize;
   logic [1:0] m_wburst;
   int m_wrem = 0;

   task automatic push_rd(logic [IW-1:0] id, logic [31:0] addr, logic [7:0] len,
                          logic [2:0] size, logic [1:0] burst);
      rbeat_t e;
      logic [31:0] a;
      bit er;
      a = addr;
      er = is_err(burst, len);
      for (int i = 0; i <= int'(len); i++) begin
         e.id = id;
         e.data = er ? 64'd0 : ref_rd(word_of(a));
         e.resp = er ? 2'b10 : 2'b00;
         e.last = (i == int'(len));
         rq.push_back(e);
         a = next_a(a, len, size, burst);
      end
   endtask

   task automatic set_aw(logic [IW-1:0] id, logic [31:0] addr, logic [7:0] len,
                         logic [2:0] size, logic [1:0] burst);
      m_wid = id; m_waddr = addr; m_wlen = len;
      m_wsize = size; m_wburst = burst;
      m_wrem = int'(len) + 1;
   endtask

   task automatic send_ar(logic [IW-1:0] id, logic [31:0] addr, logic [7:0] len,
                          logic [2:0] size, logic [1:0] burst);
      bit ok = 0;
      bus.arid = id; bus.araddr = addr; bus.arlen = len;
      bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (bus.arready) begin ok = 1; break; end
      end
      if (!ok) tmo("ar_handshake");
      else begin
         ar_cyc = cyc;
         push_rd(id, addr, len, size, burst);
      end
      @(posedge clock); #1;
      bus.arvalid = 1'b0;
   endtask

   task automatic send_aw(logic [IW-1:0] id, logic [31:0] addr, logic [7:0] len,
                          logic [2:0] size, logic [1:0] burst);
      bit ok = 0;
      bus.awid = id; bus.awaddr = addr; bus.awlen = len;
      bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (bus.awready) begin ok = 1; break; end
      end
      if (!ok) tmo("aw_handshake");
      else begin
         aw_cyc = cyc;
         set_aw(id, addr, len, size, burst);
      end
      @(posedge clock); #1;
      bus.awvalid = 1'b0;
   endtask

   task automatic send_w(int nb);
      bit ok;
      logic [63:0] t;
      int a;
      bresp_t eb;
      for (int i = 0; i < nb; i++) begin
         bus.wdata = wdat[i]; bus.wstrb = wstb[i];
         bus.wlast = (m_wrem == 1); bus.wvalid = 1'b1;
         ok = 0;
         for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (bus.wready) begin ok = 1; break; end
         end
         if (!ok) tmo("w_handshake");
         else begin
            if (i == 0) wf_cyc = cyc;
            wl_cyc = cyc;
            if (!is_err(m_wburst, m_wlen)) begin
               a = word_of(m_waddr);
               t = ref_rd(a);
               for (int b = 0; b < 8; b++)
                  if (wstb[i][b]) t[b*8 +: 8] = wdat[i][b*8 +: 8];
               ref_mem[a] = t;
            end
            m_waddr = next_a(m_waddr, m_wlen, m_wsize, m_wburst);
            m_wrem--;
            if (m_wrem == 0) begin
               eb.id = m_wid;
               eb.resp = is_err(m_wburst, m_wlen) ? 2'b10 : 2'b00;
               bq.push_back(eb);
            end
         end
         @(posedge clock); #1;
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
   endtask

   task automatic recv_b();
      bit ok = 0;
      bus.bready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (bus.bvalid) begin ok = 1; break; end
      end
      if (!ok) tmo("b_handshake");
      @(posedge clock); #1;
      bus.bready = 1'b0;
   endtask

   task automatic recv_r(logic [31:0] pat, int budget);
      bit done = 0;
      int k = 0;
      while (!done && k < budget) begin
         bus.rready = pat[k % 32];
         @(negedge clock);
         if (bus.rvalid && bus.rready && bus.rlast) done = 1;
         @(posedge clock); #1;
         k++;
      end
      bus.rready = 1'b0;
      if (!done) tmo("r_last_beat");
   endtask

   task automatic clr_logs();
      rd_log.delete(); addr_log.delete(); hs_log.delete();
      n_rhs = 0; n_en = 0; first_rv = -1; first_bv = -1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
      bus.awburst = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
      bus.wlast = 0; bus.wvalid = 0; bus.bready = 0; bus.arid = '0;
      bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
      bus.arvalid = 0; bus.rready = 0;
      for (int i = 0; i < 8; i++) begin
         wdat[i] = 64'h0101_0101_0101_0101 * (i + 3);
         wstb[i] = 8'hFF;
      end

      // Reset values
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_arready", bus.arready, 0);
      chk("rst_awready", bus.awready, 0);
      chk("rst_wready", bus.wready, 0);
      chk("rst_rvalid", bus.rvalid, 0);
      chk("rst_bvalid", bus.bvalid, 0);
      chk("rst_rlast", bus.rlast, 0);
      chk("rst_resp", {bus.rresp, bus.bresp}, 0);
      chk("rst_ids", {bus.rid, bus.bid}, 0);
      chk("rst_sram", {sram_en, sram_we, sram_addr}, 0);
      @(posedge clock); #1;
      reset = 1'b0;

      // INCR read, rready held high
      clr_logs();
      bus.rready = 1'b1;
      send_ar(4'h1, 32'h100, 8'd3, 3'd3, 2'b01);
      recv_r(32'hFFFF_FFFF, 50);
      chk("incr_en_count", n_en, 4);
      for (int i = 0; i < 4; i++)
         chk("incr_sram_addr", i < addr_log.size() ? addr_log[i] : 'x, 16'h20 + i);
      chk("incr_first_rvalid", first_rv - ar_cyc, 2);
      chk("incr_b2b", hs_log.size() == 4 ? hs_log[3] - hs_log[0] : -1, 3);

      // Write then read back
      wdat[0] = 64'h1111_1111_1111_1111; wstb[0] = 8'hFF;
      wdat[1] = 64'h2222_2222_2222_2222; wstb[1] = 8'h0F;
      clr_logs();
      send_aw(4'h5, 32'h40, 8'd1, 3'd3, 2'b01);
      send_w(2);
      recv_b();
      chk("wr_bresp", last_bresp, 2'b00);
      chk("wr_bid", last_bid, 4'h5);
      chk("wr_wready_lat", wf_cyc - aw_cyc, 1);
      chk("wr_bvalid_lat", first_bv - wl_cyc, 1);
      clr_logs();
      send_ar(4'h6, 32'h40, 8'd1, 3'd3, 2'b01);
      recv_r(32'hFFFF_FFFF, 50);
      chk("rb_word8", rd_log.size() > 0 ? rd_log[0] : 'x, 64'h1111_1111_1111_1111);
      chk("rb_word9", rd_log.size() > 1 ? rd_log[1] : 'x, 64'hC0DE_0009_2222_2222);

      // Backpressure 1,0,0,1
      clr_logs();
      send_ar(4'h2, 32'h200, 8'd3, 3'd3, 2'b01);
      recv_r(32'h9999_9999, 100);
      chk("bp_handshakes", n_rhs, 4);

      // Arbitration straight out of reset
      reset = 1'b1;
      bus.arid = 4'h3; bus.araddr = 32'h300; bus.arlen = 8'd0;
      bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
      bus.awid = 4'h4; bus.awaddr = 32'h308; bus.awlen = 8'd0;
      bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b1;
      repeat (2) @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("arb1_arready", bus.arready, 1);
      chk("arb1_awready", bus.awready, 0);
      if (bus.arready) push_rd(4'h3, 32'h300, 8'd0, 3'd3, 2'b01);
      @(posedge clock); #1;
      bus.arvalid = 1'b0; bus.awvalid = 1'b0;
      recv_r(32'hFFFF_FFFF, 50);
      bus.arvalid = 1'b1; bus.araddr = 32'h310; bus.awvalid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.arready || bus.awready) break;
      end
      chk("arb2_awready", bus.awready, 1);
      chk("arb2_arready", bus.arready, 0);
      if (bus.awready) set_aw(4'h4, 32'h308, 8'd0, 3'd3, 2'b01);
      @(posedge clock); #1;
      bus.arvalid = 1'b0; bus.awvalid = 1'b0;
      wdat[0] = 64'hDEAD_BEEF_0123_4567; wstb[0] = 8'hFF;
      send_w(1);
      recv_b();

      // WRAP read
      clr_logs();
      send_ar(4'h7, 32'h38, 8'd3, 3'd3, 2'b10);
      recv_r(32'hFFFF_FFFF, 50);
`ifdef AXI_SRAM_WRAP_BURST_EN
      chk("wrap_en_count", n_en, 4);
      chk("wrap_beat0", rd_log.size() > 0 ? rd_log[0] : 'x, 64'hC0DE_0007_BEEF_0007);
      chk("wrap_beat1", rd_log.size() > 1 ? rd_log[1] : 'x, 64'hC0DE_0004_BEEF_0004);
      chk("wrap_beat2", rd_log.size() > 2 ? rd_log[2] : 'x, 64'hC0DE_0005_BEEF_0005);
      chk("wrap_beat3", rd_log.size() > 3 ? rd_log[3] : 'x, 64'hC0DE_0006_BEEF_0006);
      chk("wrap_rresp", last_rresp, 2'b00);
`else
      chk("wrap_en_count", n_en, 0);
      chk("wrap_beats", n_rhs, 4);
      chk("wrap_beat0", rd_log.size() > 0 ? rd_log[0] : 'x, 64'd0);
      chk("wrap_rresp", last_rresp, 2'b10);
`endif

      // Burst type 11 write: drained, no SRAM access, SLVERR
      clr_logs();
      send_aw(4'h9, 32'h500, 8'd1, 3'd3, 2'b11);
      send_w(2);
      recv_b();
      chk("errw_bresp", last_bresp, 2'b10);
      chk("errw_en_count", n_en, 0);
      clr_logs();
      send_ar(4'h9, 32'h500, 8'd0, 3'd3, 2'b01);
      recv_r(32'hFFFF_FFFF, 50);
      chk("errw_untouched", rd_log.size() > 0 ? rd_log[0] : 'x, 64'hC0DE_00A0_BEEF_00A0);

      // len=255 and address wrap at top of SRAM
      clr_logs();
      send_ar(4'hC, 32'h8000, 8'd255, 3'd3, 2'b01);
      recv_r(32'hFFFF_FFFF, 400);
      chk("len255_beats", n_rhs, 256);
      clr_logs();
      send_ar(4'hA, 32'hFFF7_FFF8, 8'd1, 3'd3, 2'b01);
      recv_r(32'hFFFF_FFFF, 50);
      chk("top_addr0", addr_log.size() > 0 ? addr_log[0] : 'x, 16'hFFFF);
      chk("top_addr1", addr_log.size() > 1 ? addr_log[1] : 'x, 16'h0000);

      // Reset on beat 2 of an 8-beat write
      for (int i = 0; i < 8; i++) begin
         wdat[i] = 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 1);
         wstb[i] = 8'hFF;
      end
      clr_logs();
      send_aw(4'hB, 32'h1000, 8'd7, 3'd3, 2'b01);
      send_w(2);
      bus.wdata = wdat[2]; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; bus.wvalid = 1'b0;
      @(negedge clock);
      chk("mid_rst_wready", bus.wready, 0);
      chk("mid_rst_awready", bus.awready, 0);
      chk("mid_rst_arready", bus.arready, 0);
      chk("mid_rst_valids", {bus.rvalid, bus.bvalid}, 0);
      chk("mid_rst_sram_en", sram_en, 0);
      @(posedge clock); #1;
      clr_logs();
      send_ar(4'hD, 32'h1000, 8'd1, 3'd3, 2'b01);
      chk("mid_rst_idle_ar", ar_cyc, cyc - 1);
      recv_r(32'hFFFF_FFFF, 50);
      chk("mid_rst_beat0", rd_log.size() > 0 ? rd_log[0] : 'x, 64'hA5A5_0000_0000_0001);
      chk("mid_rst_beat1", rd_log.size() > 1 ? rd_log[1] : 'x, 64'hA5A5_0000_0000_0012);

      chk("rq_drained", rq.size(), 0);
      chk("bq_drained", bq.size(), 0);
      repeat (2) @(posedge clock);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
